// File: rtl/stopwatch.sv
// SS.cc stopwatch: a prescaler divides clk into a tick, and a BCD ripple counter
// advances the hundredths/seconds digits on every tick, flagging the 59.99 wrap.
module stopwatch #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_en,
    input  logic       pause,
    input  logic       clear,
    output logic       clk_out,
    output logic [2:0] time_sec_h,
    output logic [3:0] time_sec_l,
    output logic [3:0] time_msec_h,
    output logic [3:0] time_msec_l,
    output logic       time_out
);

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(TICK_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          at_max;

    assign tick   = (div_cnt == DIV_LAST);
    assign at_max = (time_sec_h == 3'd5) && (time_sec_l == 4'd9) &&
                    (time_msec_h == 4'd9) && (time_msec_l == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            clk_out     <= 1'b0;
            time_out    <= 1'b0;
            time_sec_h  <= '0;
            time_sec_l  <= '0;
            time_msec_h <= '0;
            time_msec_l <= '0;
        end else if (clear) begin
            div_cnt     <= '0;
            clk_out     <= 1'b0;
            time_out    <= 1'b0;
            time_sec_h  <= '0;
            time_sec_l  <= '0;
            time_msec_h <= '0;
            time_msec_l <= '0;
        end else if (!sw_en || pause) begin
            // divider is frozen too, so resuming neither loses nor adds a tick
            time_out <= 1'b0;
        end else begin
            clk_out  <= (div_cnt < DIV_HALF);
            time_out <= tick && at_max;
            if (tick) begin
                div_cnt <= '0;
                if (time_msec_l != 4'd9) begin
                    time_msec_l <= time_msec_l + 4'd1;
                end else begin
                    time_msec_l <= 4'd0;
                    if (time_msec_h != 4'd9) begin
                        time_msec_h <= time_msec_h + 4'd1;
                    end else begin
                        time_msec_h <= 4'd0;
                        if (time_sec_l != 4'd9) begin
                            time_sec_l <= time_sec_l + 4'd1;
                        end else begin
                            time_sec_l <= 4'd0;
                            if (time_sec_h != 3'd5) begin
                                time_sec_h <= time_sec_h + 3'd1;
                            end else begin
                                time_sec_h <= 3'd0;
                            end
                        end
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stopwatch.sv
// Stopwatch bench: randomized control phases checked every cycle against a
// tick-count reference model, plus directed milestones, wrap and async reset.
`timescale 1ns/1ps
module tb_stopwatch;
    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_en = 1'b1;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic       clk_out;
    logic [2:0] time_sec_h;
    logic [3:0] time_sec_l;
    logic [3:0] time_msec_h;
    logic [3:0] time_msec_l;
    logic       time_out;

    stopwatch #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .sw_en(sw_en), .pause(pause), .clear(clear),
        .clk_out(clk_out), .time_sec_h(time_sec_h), .time_sec_l(time_sec_l),
        .time_msec_h(time_msec_h), .time_msec_l(time_msec_l), .time_out(time_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference: total ticks counted and position within the current tick period
    int m_ticks = 0;
    int m_div   = 0;
    bit m_clko  = 0;
    bit m_to    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // display as a decimal SSCC number, e.g. 59.98 -> 5998
    function automatic logic [31:0] shown();
        return 32'(time_sec_h) * 1000 + 32'(time_sec_l) * 100 +
               32'(time_msec_h) * 10 + 32'(time_msec_l);
    endfunction

    function automatic logic [31:0] expect_disp();
        return 32'(m_ticks % 6000);
    endfunction

    task automatic model_zero();
        m_ticks = 0; m_div = 0; m_clko = 0; m_to = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst || clear) begin
            model_zero();
        end else if (!sw_en || pause) begin
            m_to = 0;
        end else begin
            m_clko = (m_div < TD / 2);
            if (m_div == TD - 1) begin
                m_div = 0;
                m_ticks++;
                m_to = (m_ticks % 6000 == 0);
            end else begin
                m_div++;
                m_to = 0;
            end
        end
        #1;
        chk("display", shown(), expect_disp());
        chk("clk_out", {31'b0, clk_out}, {31'b0, m_clko});
        chk("time_out", {31'b0, time_out}, {31'b0, m_to});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int saved;
        int rem;
        int pulses;

        rst = 1'b1;
        #2;
        chk("reset_async_disp", shown(), 0);
        run(3);
        rst = 1'b0;

        run(1000);
        chk("run_1000", shown(), 100);
        run(11000);
        chk("run_120us", shown(), 1200);

        run(3);
        saved = m_ticks % 6000;
        rem   = TD - 1 - m_div;
        pause = 1'b1;
        run(1000);
        chk("pause_hold", shown(), saved);
        pause = 1'b0;
        run(rem);
        chk("pause_resume_early", shown(), saved);
        run(1);
        chk("pause_resume_tick", shown(), saved + 1);

        saved = m_ticks % 6000;
        sw_en = 1'b0;
        run(1000);
        chk("swen_hold", shown(), saved);
        sw_en = 1'b1;
        run(50);

        clear = 1'b1;
        run(500);
        pause = 1'b1;
        run(500);
        chk("clear_over_pause", shown(), 0);
        clear = 1'b0;
        pause = 1'b0;
        run(10);
        chk("clear_then_10", shown(), 1);

        // random control phases
        for (int seg = 0; seg < 200; seg++) begin
            int r;
            r = $urandom_range(0, 15);
            sw_en = (r != 0);
            pause = (r == 1) || (r == 2);
            clear = (r == 3) && ($urandom_range(0, 3) == 0);
            run($urandom_range(1, 25));
        end
        sw_en = 1'b1; pause = 1'b0; clear = 1'b0;

        clear = 1'b1;
        run(1);
        clear = 1'b0;
        run(5998 * TD);
        chk("reach_5998", shown(), 5998);
        pulses = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            cyc();
            if (time_out === 1'b1) pulses++;
        end
        chk("wrap_display", shown(), 0);
        chk("wrap_pulses", 32'(pulses), 1);
        run(1);
        chk("wrap_pulse_gone", {31'b0, time_out}, 0);

        run(15);
        chk("pre_rst_count", shown(), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_disp", shown(), 0);
        chk("async_rst_clk_out", {31'b0, clk_out}, 0);
        model_zero();
        run(3);
        rst = 1'b0;
        run(25);
        chk("after_rst_run", shown(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
